// File: rtl/ring_ptr_alloc_if.sv
// Request/response bundle between a circular-queue user and ring_ptr_alloc.
// The master side issues alloc/commit/squash; the slave side reports pointers and occupancy.
interface ring_ptr_alloc_if #(
  parameter int SIZE         = 128,
  parameter int ALLOC_WIDTH  = 4,
  parameter int COMMIT_WIDTH = 4
);
  localparam int IDXW = $clog2(SIZE);
  localparam int AW   = $clog2(ALLOC_WIDTH + 1);
  localparam int CW   = $clog2(COMMIT_WIDTH + 1);
  localparam int NW   = $clog2(SIZE + 1);

  logic [AW-1:0]                   i_alloc_num;
  logic                            o_can_alloc;
  logic [ALLOC_WIDTH-1:0][IDXW:0]  o_alloc_ptr;
  logic [CW-1:0]                   i_commit_num;
  logic                            i_squash_vld;
  logic [IDXW:0]                   i_squash_ptr;
  logic [IDXW:0]                   o_head;
  logic [IDXW:0]                   o_tail;
  logic [NW-1:0]                   o_count;
  logic                            o_empty;
  logic                            o_full;

  modport master (
    output i_alloc_num, i_commit_num, i_squash_vld, i_squash_ptr,
    input  o_can_alloc, o_alloc_ptr, o_head, o_tail, o_count, o_empty, o_full
  );

  modport slave (
    input  i_alloc_num, i_commit_num, i_squash_vld, i_squash_ptr,
    output o_can_alloc, o_alloc_ptr, o_head, o_tail, o_count, o_empty, o_full
  );
endinterface

// File: rtl/ring_ptr_alloc.sv
// Circular-queue pointer manager for any queue depth (power of 2 or not).
// Pointers are {flip, idx}; flip toggles every time idx wraps past SIZE-1,
// which lets equal indices be told apart as full vs empty and gives an age order.

package ring_ptr_alloc_pkg;
  // a is older than b: same lap compares indices directly, different laps reverse it.
  function automatic logic isOlder(input logic aFlip, input int unsigned aIdx,
                                   input logic bFlip, input int unsigned bIdx);
    return (aFlip == bFlip) ? (aIdx < bIdx) : (aIdx > bIdx);
  endfunction
endpackage

module ring_ptr_alloc #(
  parameter int SIZE         = 128,
  parameter int ALLOC_WIDTH  = 4,
  parameter int COMMIT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  ring_ptr_alloc_if.slave  bus
);
  localparam int IDXW = $clog2(SIZE);
  localparam int PW   = IDXW + 1;
  localparam int NW   = $clog2(SIZE + 1);

  typedef struct packed {
    logic            flip;
    logic [IDXW-1:0] idx;
  } ptr_t;

  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  logic [NW-1:0] count_q, count_d;
  logic          canAlloc_q, empty_q, full_q;

  ptr_t          sqPtr;
  logic [NW-1:0] commitReq, commitEff, allocN, countAfterCommit;
  logic          allocFire;

  // Advance by n with an explicit compare against SIZE so non-power-of-2 depths wrap correctly.
  function automatic ptr_t advance(input ptr_t p, input logic [PW-1:0] n);
    logic [PW-1:0] s;
    ptr_t          r;
    s = {1'b0, p.idx} + n;
    if (s >= PW'(SIZE)) begin
      r.idx  = IDXW'(s - PW'(SIZE));
      r.flip = ~p.flip;
    end else begin
      r.idx  = s[IDXW-1:0];
      r.flip = p.flip;
    end
    return r;
  endfunction

  // Number of entries from a (inclusive) up to b (exclusive), assuming a is not younger than b.
  function automatic logic [NW-1:0] distance(input ptr_t a, input ptr_t b);
    if (a.flip == b.flip)
      return NW'(b.idx) - NW'(a.idx);
    else
      return NW'(SIZE) - NW'(a.idx) + NW'(b.idx);
  endfunction

  assign sqPtr = bus.i_squash_ptr;

  // Next-state: commit always moves the head; squash overrides alloc for the tail and recomputes occupancy.
  always_comb begin
    commitReq        = NW'(bus.i_commit_num);
    commitEff        = (commitReq > count_q) ? count_q : commitReq;
    allocFire        = canAlloc_q && (bus.i_alloc_num != '0) && !bus.i_squash_vld;
    allocN           = allocFire ? NW'(bus.i_alloc_num) : '0;
    countAfterCommit = count_q - commitEff;
    head_d           = advance(head_q, PW'(commitEff));
    tail_d           = tail_q;
    count_d          = countAfterCommit + allocN;
    if (bus.i_squash_vld) begin
      tail_d  = sqPtr;
      count_d = distance(head_d, sqPtr);
    end else if (allocFire) begin
      tail_d  = advance(tail_q, PW'(bus.i_alloc_num));
    end
  end

  // Slot k of an allocation group lands at tail+k, whether or not slot k is requested.
  always_comb begin
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      bus.o_alloc_ptr[k] = advance(tail_q, PW'(k));
    end
  end

  // State and occupancy flags are registered so consumers see them one cycle after each event.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      canAlloc_q <= 1'b1;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      canAlloc_q <= (NW'(SIZE) - count_d) >= NW'(ALLOC_WIDTH);
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == NW'(SIZE));
    end
  end

  // Illegal requests from the surrounding pipeline are trapped in simulation only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(bus.i_alloc_num) <= ALLOC_WIDTH);
      assert (int'(bus.i_commit_num) <= COMMIT_WIDTH);
      assert (commitReq <= count_q);
      assert (count_q <= NW'(SIZE));
      if (bus.i_squash_vld) begin
        assert (distance(head_d, sqPtr) <= countAfterCommit);
      end
    end
  end

  assign bus.o_head      = head_q;
  assign bus.o_tail      = tail_q;
  assign bus.o_count     = count_q;
  assign bus.o_can_alloc = canAlloc_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_full      = full_q;

endmodule

// File: tb/tb_ring_ptr_alloc.sv
// Bench for ring_ptr_alloc at SIZE=40: directed scenarios plus a random run,
// checked against a model that tracks head/tail as unbounded absolute positions.
module tb_ring_ptr_alloc;
  localparam int SIZE = 40;
  localparam int AWID = 4;
  localparam int CWID = 4;
  localparam int IDXW = $clog2(SIZE);
  localparam int AW   = $clog2(AWID + 1);
  localparam int CW   = $clog2(CWID + 1);
  localparam int NW   = $clog2(SIZE + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   mHead = 0;
  int   mTail = 0;

  ring_ptr_alloc_if #(.SIZE(SIZE), .ALLOC_WIDTH(AWID), .COMMIT_WIDTH(CWID)) bus ();

  ring_ptr_alloc #(.SIZE(SIZE), .ALLOC_WIDTH(AWID), .COMMIT_WIDTH(CWID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [IDXW:0] mkPtr(input int f, input int i);
    return (IDXW+1)'(f * (2 ** IDXW) + i);
  endfunction

  function automatic logic [IDXW:0] ptrOf(input int absPos);
    return mkPtr((absPos / SIZE) % 2, absPos % SIZE);
  endfunction

  function automatic int minI(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit modelCanAlloc();
    return (SIZE - (mTail - mHead)) >= AWID;
  endfunction

  // One clock of stimulus; the model follows the queue rules using absolute positions.
  task automatic stepCycle(input int a, input int c, input bit sq, input int sqAbs, input bit r);
    bit fire;
    bus.i_alloc_num  = AW'(a);
    bus.i_commit_num = CW'(c);
    bus.i_squash_vld = sq;
    bus.i_squash_ptr = ptrOf(sqAbs);
    rst              = r;
    fire = modelCanAlloc() && (a != 0) && !sq;
    @(posedge clk);
    if (r) begin
      mHead = 0;
      mTail = 0;
    end else begin
      mHead += c;
      if (sq) mTail = sqAbs;
      else if (fire) mTail += a;
    end
    #1;
    bus.i_alloc_num  = '0;
    bus.i_commit_num = '0;
    bus.i_squash_vld = 1'b0;
  endtask

  // Walk the queue to absolute tail/head targets using only legal alloc/commit requests.
  task automatic driveTo(input int tT, input int tH);
    int guard = 0;
    int a, c;
    while ((mTail < tT || mHead < tH) && guard < 200) begin
      a = modelCanAlloc() ? minI(AWID, tT - mTail) : 0;
      c = minI(CWID, minI(tH - mHead, mTail - mHead));
      stepCycle(a, c, 1'b0, 0, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL driveTo_timeout head=%0d tail=%0d want %0d/%0d", mHead, mTail, tH, tT);
    end
  endtask

  task automatic doReset();
    stepCycle(0, 0, 1'b0, 0, 1'b1);
    stepCycle(0, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.o_head !== mkPtr(0,0)) begin failures++; $display("FAIL reset_head got=%h exp=%h", bus.o_head, mkPtr(0,0)); end
    checks++; if (bus.o_tail !== mkPtr(0,0)) begin failures++; $display("FAIL reset_tail got=%h exp=%h", bus.o_tail, mkPtr(0,0)); end
    checks++; if (bus.o_count !== NW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.o_count); end
    checks++; if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_can_alloc !== 1'b1) begin
      failures++; $display("FAIL reset_flags got e=%b f=%b ca=%b exp e=1 f=0 ca=1", bus.o_empty, bus.o_full, bus.o_can_alloc);
    end
    for (int k = 0; k < AWID; k++) begin
      checks++; if (bus.o_alloc_ptr[k] !== mkPtr(0,k)) begin failures++; $display("FAIL reset_allocptr%0d got=%h exp=%h", k, bus.o_alloc_ptr[k], mkPtr(0,k)); end
    end
  endtask

  task automatic test_wrap();
    logic [IDXW:0] expPtr [4];
    expPtr[0] = mkPtr(0,38); expPtr[1] = mkPtr(0,39); expPtr[2] = mkPtr(1,0); expPtr[3] = mkPtr(1,1);
    doReset();
    driveTo(38, 30);
    checks++; if (bus.o_head !== mkPtr(0,30) || bus.o_tail !== mkPtr(0,38)) begin
      failures++; $display("FAIL wrap_setup got h=%h t=%h exp h=%h t=%h", bus.o_head, bus.o_tail, mkPtr(0,30), mkPtr(0,38));
    end
    for (int k = 0; k < AWID; k++) begin
      checks++; if (bus.o_alloc_ptr[k] !== expPtr[k]) begin failures++; $display("FAIL wrap_allocptr%0d got=%h exp=%h", k, bus.o_alloc_ptr[k], expPtr[k]); end
    end
    stepCycle(4, 0, 1'b0, 0, 1'b0);
    checks++; if (bus.o_tail !== mkPtr(1,2)) begin failures++; $display("FAIL wrap_tail got=%h exp=%h", bus.o_tail, mkPtr(1,2)); end
    checks++; if (bus.o_count !== NW'(12)) begin failures++; $display("FAIL wrap_count got=%0d exp=12", bus.o_count); end
  endtask

  task automatic test_full();
    doReset();
    driveTo(37, 0);
    checks++; if (bus.o_count !== NW'(37) || bus.o_can_alloc !== 1'b0) begin
      failures++; $display("FAIL full_37 got cnt=%0d ca=%b exp cnt=37 ca=0", bus.o_count, bus.o_can_alloc);
    end
    stepCycle(4, 0, 1'b0, 0, 1'b0);
    checks++; if (bus.o_count !== NW'(37) || bus.o_tail !== mkPtr(0,37)) begin
      failures++; $display("FAIL full_ignored got cnt=%0d t=%h exp cnt=37 t=%h", bus.o_count, bus.o_tail, mkPtr(0,37));
    end
    stepCycle(0, 1, 1'b0, 0, 1'b0);
    checks++; if (bus.o_count !== NW'(36) || bus.o_can_alloc !== 1'b1) begin
      failures++; $display("FAIL full_commit1 got cnt=%0d ca=%b exp cnt=36 ca=1", bus.o_count, bus.o_can_alloc);
    end
    stepCycle(4, 0, 1'b0, 0, 1'b0);
    checks++; if (bus.o_count !== NW'(40) || bus.o_full !== 1'b1 || bus.o_can_alloc !== 1'b0 || bus.o_tail !== mkPtr(1,1)) begin
      failures++; $display("FAIL full_40 got cnt=%0d f=%b ca=%b t=%h exp cnt=40 f=1 ca=0 t=%h", bus.o_count, bus.o_full, bus.o_can_alloc, bus.o_tail, mkPtr(1,1));
    end
    stepCycle(4, 4, 1'b0, 0, 1'b0);
    checks++; if (bus.o_count !== NW'(36) || bus.o_full !== 1'b0) begin
      failures++; $display("FAIL full_drain got cnt=%0d f=%b exp cnt=36 f=0", bus.o_count, bus.o_full);
    end
  endtask

  task automatic test_squash();
    doReset();
    driveTo(20, 5);
    checks++; if (bus.o_head !== mkPtr(0,5) || bus.o_tail !== mkPtr(0,20) || bus.o_count !== NW'(15)) begin
      failures++; $display("FAIL squash_setup got h=%h t=%h cnt=%0d exp h=%h t=%h cnt=15", bus.o_head, bus.o_tail, bus.o_count, mkPtr(0,5), mkPtr(0,20));
    end
    stepCycle(4, 2, 1'b1, 10, 1'b0);
    checks++; if (bus.o_tail !== mkPtr(0,10)) begin failures++; $display("FAIL squash_tail got=%h exp=%h", bus.o_tail, mkPtr(0,10)); end
    checks++; if (bus.o_head !== mkPtr(0,7)) begin failures++; $display("FAIL squash_head got=%h exp=%h", bus.o_head, mkPtr(0,7)); end
    checks++; if (bus.o_count !== NW'(3)) begin failures++; $display("FAIL squash_count got=%0d exp=3", bus.o_count); end
  endtask

  task automatic test_cross_flip();
    doReset();
    driveTo(43, 38);
    checks++; if (bus.o_head !== mkPtr(0,38) || bus.o_tail !== mkPtr(1,3) || bus.o_count !== NW'(5)) begin
      failures++; $display("FAIL xflip_setup got h=%h t=%h cnt=%0d exp h=%h t=%h cnt=5", bus.o_head, bus.o_tail, bus.o_count, mkPtr(0,38), mkPtr(1,3));
    end
    stepCycle(2, 3, 1'b0, 0, 1'b0);
    checks++; if (bus.o_head !== mkPtr(1,1)) begin failures++; $display("FAIL xflip_head got=%h exp=%h", bus.o_head, mkPtr(1,1)); end
    checks++; if (bus.o_tail !== mkPtr(1,5)) begin failures++; $display("FAIL xflip_tail got=%h exp=%h", bus.o_tail, mkPtr(1,5)); end
    checks++; if (bus.o_count !== NW'(4)) begin failures++; $display("FAIL xflip_count got=%0d exp=4", bus.o_count); end
    checks++; if (ring_ptr_alloc_pkg::isOlder(1'b0, 39, 1'b1, 0) !== 1'b1) begin failures++; $display("FAIL age_older got=0 exp=1"); end
    checks++; if (ring_ptr_alloc_pkg::isOlder(1'b1, 0, 1'b0, 39) !== 1'b0) begin failures++; $display("FAIL age_younger got=1 exp=0"); end
    checks++; if (ring_ptr_alloc_pkg::isOlder(1'b1, 3, 1'b1, 7) !== 1'b1) begin failures++; $display("FAIL age_samelap got=0 exp=1"); end
  endtask

  task automatic test_reset_midop();
    doReset();
    driveTo(20, 0);
    stepCycle(4, 0, 1'b1, 5, 1'b1);
    checks++; if (bus.o_head !== mkPtr(0,0) || bus.o_tail !== mkPtr(0,0) || bus.o_count !== NW'(0)) begin
      failures++; $display("FAIL midrst_state got h=%h t=%h cnt=%0d exp all zero", bus.o_head, bus.o_tail, bus.o_count);
    end
    checks++; if (bus.o_empty !== 1'b1 || bus.o_can_alloc !== 1'b1) begin
      failures++; $display("FAIL midrst_flags got e=%b ca=%b exp e=1 ca=1", bus.o_empty, bus.o_can_alloc);
    end
    stepCycle(0, 0, 1'b0, 0, 1'b0);
    checks++; if (bus.o_count !== NW'(0) || bus.o_tail !== mkPtr(0,0)) begin
      failures++; $display("FAIL midrst_after got cnt=%0d t=%h exp cnt=0 t=%h", bus.o_count, bus.o_tail, mkPtr(0,0));
    end
  endtask

  task automatic test_random();
    int a, c, cnt, sqAbs;
    bit sq;
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < AWID; k++) begin
        checks++; if (bus.o_alloc_ptr[k] !== ptrOf(mTail + k)) begin
          failures++; $display("FAIL rand_allocptr%0d cyc=%0d got=%h exp=%h", k, cyc, bus.o_alloc_ptr[k], ptrOf(mTail + k));
        end
      end
      cnt   = mTail - mHead;
      a     = int'($urandom_range(0, AWID));
      c     = int'($urandom_range(0, minI(CWID, cnt)));
      sq    = ($urandom_range(0, 9) == 0);
      sqAbs = sq ? int'($urandom_range(mHead + c, mTail)) : 0;
      stepCycle(a, c, sq, sqAbs, 1'b0);
      cnt = mTail - mHead;
      checks++; if (bus.o_head !== ptrOf(mHead)) begin failures++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, bus.o_head, ptrOf(mHead)); end
      checks++; if (bus.o_tail !== ptrOf(mTail)) begin failures++; $display("FAIL rand_tail cyc=%0d got=%h exp=%h", cyc, bus.o_tail, ptrOf(mTail)); end
      checks++; if (bus.o_count !== NW'(cnt)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, bus.o_count, cnt); end
      checks++; if (bus.o_empty !== (cnt == 0) || bus.o_full !== (cnt == SIZE) || bus.o_can_alloc !== modelCanAlloc()) begin
        failures++; $display("FAIL rand_flags cyc=%0d got e=%b f=%b ca=%b exp e=%b f=%b ca=%b", cyc, bus.o_empty, bus.o_full, bus.o_can_alloc, cnt == 0, cnt == SIZE, modelCanAlloc());
      end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    bus.i_alloc_num  = '0;
    bus.i_commit_num = '0;
    bus.i_squash_vld = 1'b0;
    bus.i_squash_ptr = '0;
    #1;
    test_reset();
    test_wrap();
    test_full();
    test_squash();
    test_cross_flip();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the run stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/ring_ptr_alloc.md
Name: ring_ptr_alloc

Overview:
- Parametrised circular-queue pointer manager for ROB, immBuffer, FTQ and dispatch queues.
- Generalises the fixed power-of-2 {flipped, idx} robIdx_t scheme to any SIZE, including non-power-of-2 sizes such as IMMBUFFER_SIZE=40.
- Supports multi-entry allocate and multi-entry commit per cycle, plus squash rollback of the tail.
- Sits between rename/dispatch (allocation), commit (retire) and the redirect/squash path.

Parameters:
- SIZE, 128, number of queue entries; must be >= 2 and >= ALLOC_WIDTH, need not be a power of 2.
- ALLOC_WIDTH, 4, maximum entries allocated per cycle.
- COMMIT_WIDTH, 4, maximum entries freed per cycle.
- Derived:
  - IDXW = $clog2(SIZE).
  - Pointer = {flip(1), idx(IDXW)}, width IDXW+1.
  - AW = $clog2(ALLOC_WIDTH+1).
  - CW = $clog2(COMMIT_WIDTH+1).
  - NW = $clog2(SIZE+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_alloc_num  in  AW  entries requested this cycle (0..ALLOC_WIDTH).
- o_can_alloc  out  1  free entries >= ALLOC_WIDTH.
- o_alloc_ptr  out  ALLOC_WIDTH x (IDXW+1)  pointer assigned to request slot k.
- i_commit_num  in  CW  entries retired this cycle (0..COMMIT_WIDTH).
- i_squash_vld  in  1  rollback tail.
- i_squash_ptr  in  IDXW+1  new tail (first squashed entry).
- o_head  out  IDXW+1  oldest live entry.
- o_tail  out  IDXW+1  next entry to allocate.
- o_count  out  NW  live entries.
- o_empty  out  1  count==0.
- o_full  out  1  count==SIZE.

Behaviour:
- Reset:
  - head = tail = {0,0}, count = 0, empty = 1, full = 0.
  - can_alloc = 1.
  - o_alloc_ptr[k] = {0,k}.
  - Reset asserted mid-operation discards all state the following cycle, regardless of concurrent inputs.
- Pointer advance, ptr + n (n <= max(ALLOC_WIDTH, COMMIT_WIDTH)):
  - s = idx + n, computed at IDXW+1 bits.
  - If s >= SIZE: idx = s - SIZE and flip toggles; else idx = s.
  - Never use a power-of-2 mask.
- o_alloc_ptr[k] = tail + k. Purely combinational from the registered tail; valid for all k regardless of i_alloc_num.
- Alloc fires when o_can_alloc && i_alloc_num != 0 && !i_squash_vld.
  - Tail advances by i_alloc_num at the next edge.
  - Allocation with o_can_alloc = 0 is ignored; the requester must stall.
- Commit: head advances by i_commit_num at the next edge.
  - i_commit_num > count is illegal; RTL saturates to count and asserts in simulation.
- Squash:
  - tail <= i_squash_ptr; takes priority over any same-cycle alloc, which is dropped.
  - Caller guarantees i_squash_ptr lies in [head_after_commit, tail] in age order.
  - Commit in the same cycle still applies.
- count is a register updated as count + alloc_fired_num - commit_num.
  - On squash, count = distance(head_next, i_squash_ptr).
  - distance(a, b) = (a.flip == b.flip) ? b.idx - a.idx : SIZE - a.idx + b.idx.
- o_can_alloc = (SIZE - count) >= ALLOC_WIDTH, from registered count only (no same-cycle commit bypass).
- o_empty and o_full derive from registered count.
- Latency:
  - All outputs except o_alloc_ptr are registered; state changes are visible 1 cycle after the event.
  - Age compare helper: a is older than b iff (a.flip == b.flip) ? a.idx < b.idx : a.idx > b.idx.
  - Expose the compare as a function in the same file for ROB users.
- Simultaneous alloc + commit at full/empty boundaries is legal. Commit of the last entry with a same-cycle alloc yields count = alloc_num.
- Simulation assertions:
  - i_alloc_num <= ALLOC_WIDTH.
  - i_commit_num <= COMMIT_WIDTH.
  - count <= SIZE.
  - Squash pointer in range.

Test Plan (SIZE=40, ALLOC_WIDTH=4, COMMIT_WIDTH=4):
- rst for 2 cycles -> head = tail = {0,0}, count 0, empty 1, can_alloc 1; o_alloc_ptr = {0,0},{0,1},{0,2},{0,3}.
- Wrap: tail = {0,38}, head = {0,30}, alloc 4 -> o_alloc_ptr = {0,38},{0,39},{1,0},{1,1}; next cycle tail {1,2}, count 12.
- Full: fill to count 37 -> can_alloc 0. Alloc 4 -> ignored. Commit 1 -> next cycle count 36, can_alloc 1. Fill to 40 via partial allocs -> full 1.
- Squash vs alloc: head {0,5}, tail {0,20}; squash_ptr {0,10} + alloc 4 + commit 2 -> tail {0,10}, head {0,7}, count 3.
- Cross-flip commit/alloc: head {0,38}, tail {1,3}, count 5; commit 3 + alloc 2 -> head {1,1}, tail {1,5}, count 4. Age compare: {0,39} older than {1,0} true.
- Reset mid-op: count 20 with alloc 4 and squash asserted alongside rst -> next cycle all reset values, no alloc recorded.
